fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_pkg.sv | 23 ++
 rtl/fifo_rd_stream.sv | 132 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_pkg
// Shared definitions for fifo_rd_stream: buffer depth, occupancy state
// encoding, word-counter width and the modulo-3 pointer increment helper.
// -----------------------------------------------------------------------------
package fifo_rd_stream_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = 16;

    // Buffer occupancy: empty (0 words), partial (1..2 words), full (3 words).
    typedef enum logic [1:0] {
        S_EMPTY,
        S_PART,
        S_FULL
    } state_t;

    // Circular pointer increment, wrapping 2 -> 0 for the 3-entry buffer.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Converts a FIFO read port (ren/empty, one-cycle read latency) into a
// valid/ready stream. A 3-entry skid buffer absorbs the read latency so that
// o_ren never depends combinationally on i_ready, while still sustaining one
// word per clock.
//
// Ports
//   i_clk       clock (upstream FIFO read domain)
//   i_arst      asynchronous active-high reset
//   i_empty     upstream FIFO empty flag (registered on i_clk)
//   i_dataR     upstream read data, valid the cycle after an accepted read
//   o_ren       read enable to the upstream FIFO
//   i_flush     synchronous flush of buffered and in-flight words
//   o_valid     stream data valid
//   i_ready     downstream ready
//   o_data      stream data (head of the buffer)
//   o_word_cnt  completed-pop counter, only when RD_STREAM_CNT_EN is defined
//
// Configuration macro: RD_STREAM_CNT_EN (adds o_word_cnt).
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int g_width = 8
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic               i_empty,
    input  logic [g_width-1:0] i_dataR,
    output logic               o_ren,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [g_width-1:0] o_data
`ifdef RD_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0]   o_word_cnt
`endif
);

    logic [g_width-1:0] buf_q [BUF_DEPTH];
    logic [1:0]         count_q, count_d;
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic               pend_q, pend_d;
    state_t             state_q, state_d;
    logic               push;
    logic               pop;

    // A word requested last cycle lands this cycle; that is the only push.
    assign push = pend_q;
    assign pop  = o_valid && i_ready;

    // Room is judged on buffered plus in-flight words, so an issued read
    // always has a slot waiting for it and the buffer cannot overflow.
    assign o_ren = !i_arst && !i_flush && !i_empty &&
                   (({1'b0, count_q} + {2'b00, pend_q}) < 3'd3);

    assign o_valid = (state_q != S_EMPTY);
    assign o_data  = buf_q[rd_ptr_q];

    // NOTE: every signal assigned in this block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pend_d   = o_ren;

        if (i_flush) begin
            // Flush wins over push and pop; the in-flight word is forgotten.
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pend_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        case (count_d)
            2'd0:    state_d = S_EMPTY;
            2'd3:    state_d = S_FULL;
            default: state_d = S_PART;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values regardless of evaluation order.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pend_q   <= 1'b0;
            state_q  <= S_EMPTY;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
        end
    end

    // NOTE: the data storage has no reset; o_valid already masks stale
    // contents, and leaving it unreset lets it map to plain flops or LUT RAM.
    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            buf_q[wr_ptr_q] <= i_dataR;
        end
    end

`ifdef RD_STREAM_CNT_EN
    // Counts pops that actually complete; a flush cancels a same-edge pop
    // but never clears the running total. Wraps naturally at 2^CNT_W.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_word_cnt <= '0;
        end else if (pop && !i_flush) begin
            o_word_cnt <= o_word_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Self-checking bench for fifo_rd_stream. The upstream FIFO is a queue; the
// reference is a queue of buffered words plus one in-flight word, updated
// from the interface rules each clock. Outputs are sampled 1 ns after the
// falling edge, where inputs are also driven.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_arst;
    logic         i_empty;
    logic [W-1:0] i_dataR;
    logic         o_ren;
    logic         i_flush;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_data;
`ifdef RD_STREAM_CNT_EN
    logic [15:0]  o_word_cnt;
`endif

    fifo_rd_stream #(.g_width(W)) dut (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_empty (i_empty),
        .i_dataR (i_dataR),
        .o_ren   (o_ren),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
`ifdef RD_STREAM_CNT_EN
        ,
        .o_word_cnt (o_word_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Upstream FIFO contents and the reference buffer.
    logic [W-1:0] up_q[$];
    logic [W-1:0] mq[$];
    bit           m_pend;
    logic [W-1:0] m_pend_data;
    logic [W-1:0] next_data;
    logic [15:0]  m_cnt;

    // Per-cycle expectations and samples.
    bit           exp_ren, exp_valid;
    logic [W-1:0] exp_data;
    bit           seen_ren, seen_valid;
    logic [W-1:0] seen_data;

    // Delivery log for the directed literal checks.
    logic [W-1:0] got_data[$];
    int           got_cyc[$];
    int           ren_count;
    int           first_ren_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive upstream signals, compare against the reference,
    // advance upstream FIFO and reference across the rising edge.
    task automatic tick();
        i_empty = (up_q.size() == 0);
        i_dataR = next_data;
        #1;
        exp_ren   = !i_flush && !i_empty && ((mq.size() + int'(m_pend)) < 3);
        exp_valid = (mq.size() != 0);
        exp_data  = exp_valid ? mq[0] : '0;
        seen_ren   = o_ren;
        seen_valid = o_valid;
        seen_data  = o_data;
        check("ren", 32'(o_ren), 32'(exp_ren));
        check("valid", 32'(o_valid), 32'(exp_valid));
        if (exp_valid) check("data", 32'(o_data), 32'(exp_data));
`ifdef RD_STREAM_CNT_EN
        check("word_cnt", 32'(o_word_cnt), 32'(m_cnt));
`endif
        if (seen_ren) begin
            ren_count++;
            if (first_ren_cyc < 0) first_ren_cyc = cyc;
        end

        @(posedge i_clk);
        if (seen_ren && up_q.size() > 0) next_data = up_q.pop_front();
        else                             next_data = W'($urandom);

        if (i_flush) begin
            mq.delete();
            m_pend = 1'b0;
        end else begin
            if (exp_valid && i_ready) begin
                mq.delete(0);
                got_data.push_back(seen_data);
                got_cyc.push_back(cyc);
                m_cnt = m_cnt + 16'd1;
            end
            if (m_pend) mq.push_back(m_pend_data);
            m_pend      = exp_ren;
            m_pend_data = next_data;
        end
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic model_reset();
        mq.delete();
        up_q.delete();
        m_pend    = 1'b0;
        m_cnt     = '0;
        next_data = W'($urandom);
    endtask

    // Assert reset between edges and observe the outputs drop immediately.
    task automatic async_reset_pulse();
        #2 i_arst = 1'b1;
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ren", 32'(o_ren), 32'd0);
`ifdef RD_STREAM_CNT_EN
        check("rst_word_cnt", 32'(o_word_cnt), 32'd0);
`endif
        @(posedge i_clk);
        @(negedge i_clk);
        i_arst = 1'b0;
        model_reset();
        cyc++;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        i_arst  = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b0;
        i_empty = 1'b1;
        i_dataR = '0;
        first_ren_cyc = -1;
        ren_count = 0;
        model_reset();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_ren", 32'(o_ren), 32'd0);
        i_arst = 1'b0;

        // Idle upstream for 10 cycles: nothing read, nothing valid.
        for (int i = 0; i < 10; i++) begin
            i_ready = 1'($urandom);
            tick();
            check("idle_ren", 32'(seen_ren), 32'd0);
            check("idle_valid", 32'(seen_valid), 32'd0);
        end

        // Five words, sink always ready: N+2 latency, no bubbles.
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) up_q.push_back(8'h11 + 8'(i));
        got_data.delete();
        got_cyc.delete();
        first_ren_cyc = -1;
        repeat (10) tick();
        check("burst_count", 32'(got_data.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_data.size(); i++) begin
            check("burst_data", 32'(got_data[i]), 32'(8'h11 + 8'(i)));
            check("burst_cycle", 32'(got_cyc[i]), 32'(first_ren_cyc + 2 + i));
        end

        // Sink stalled: exactly three reads fill the buffer, then drain in order.
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) up_q.push_back(8'h20 + 8'(i));
        ren_count = 0;
        repeat (8) tick();
        check("stall_reads", 32'(ren_count), 32'd3);
        check("stall_ren", 32'(seen_ren), 32'd0);
        check("stall_valid", 32'(seen_valid), 32'd1);
        check("stall_head", 32'(seen_data), 32'h20);
        i_ready = 1'b1;
        got_data.delete();
        got_cyc.delete();
        repeat (15) tick();
        check("drain_count", 32'(got_data.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_data.size(); i++)
            check("drain_data", 32'(got_data[i]), 32'(8'h20 + 8'(i)));

        // Flush with two buffered words and one in flight (0x32).
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) up_q.push_back(8'h30 + 8'(i));
        repeat (3) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_ready = 1'b1;
        got_data.delete();
        got_cyc.delete();
        tick();
        check("flush_valid", 32'(seen_valid), 32'd0);
        repeat (8) tick();
        check("flush_count", 32'(got_data.size()), 32'd2);
        if (got_data.size() >= 2) begin
            check("flush_data0", 32'(got_data[0]), 32'h33);
            check("flush_data1", 32'(got_data[1]), 32'h34);
        end

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 6; i++) up_q.push_back(8'h40 + 8'(i));
        repeat (4) tick();
        check("pre_rst_valid", 32'(seen_valid), 32'd1);
        async_reset_pulse();
        repeat (3) begin
            tick();
            check("post_rst_valid", 32'(seen_valid), 32'd0);
        end

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 2) == 0 && up_q.size() < 16) up_q.push_back(W'($urandom));
            i_ready = (($urandom % 4) != 0);
            if ((i / 200) % 2 == 1) i_ready = 1'($urandom);
            i_flush = (($urandom % 40) == 0);
            tick();
        end
        i_flush = 1'b0;

`ifdef RD_STREAM_CNT_EN
        // 65537 completed pops wrap the counter round to 1.
        async_reset_pulse();
        got_data.delete();
        got_cyc.delete();
        i_ready = 1'b1;
        for (int i = 0; i < 70000 && m_cnt != 16'd1 || i < 3; i++) begin
            while (up_q.size() < 4) up_q.push_back(W'($urandom));
            if (got_data.size() > 16) begin
                got_data.delete();
                got_cyc.delete();
            end
            tick();
        end
        #1;
        check("cnt_wrap", 32'(o_word_cnt), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
